fp_addsub: RTL
==============

# fp_addsub

Parametrised, multi-cycle IEEE-754 floating-point adder/subtractor with a fixed-latency strobe handshake and exception flags. It is the next-generation FPU add unit: the exponent and mantissa widths are generic, so the same RTL serves binary32, binary16 and custom formats. It adds a runtime add/subtract select and single-cycle barrel alignment and normalisation. It sits beside the other FPU units and is driven by the same exec/done strobe protocol.

## Interface
- `EXP_W`, default 8: exponent field width (≥3).
- `MAN_W`, default 23: stored fraction width (≥2); total word `W = 1+EXP_W+MAN_W`.
- `clk`  in  1  clock, rising edge.
- `reset_n_i`  in  1  asynchronous active-low reset.
- `a_value_i`  in  W  operand A.
- `b_value_i`  in  W  operand B.
- `sub_i`  in  1  1 = compute A−B (B sign inverted), 0 = A+B.
- `exec_strobe_i`  in  1  start request; operands and `sub_i` sampled this cycle.
- `z_value_o`  out  W  result, held until next completion.
- `done_strobe_o`  out  1  one-cycle pulse, result and flags valid.
- `busy_o`  out  1  operation in flight.
- `flags_o`  out  3  {invalid, overflow, inexact}, held with result.

## Operation
- Reset (async assert): state IDLE; `z_value_o`=0, `flags_o`=0, `done_strobe_o`=0, `busy_o`=0. Reset mid-operation aborts; no done pulse follows.
- States: IDLE → CAPTURE → SPECIAL → ALIGN → ADD → NORM → ROUND → PACK → DONE → IDLE. One cycle per state; no data-dependent looping.
- IDLE: on `exec_strobe_i`, register operands and `sub_i`; `busy_o`=1. Strobes while busy are ignored.
- CAPTURE: unpack sign, biased exponent to signed `EXP_W+2`-bit unbiased value, mantissa to `MAN_W+4` bits (hidden + fraction + G/R/S); effective B sign = `b_s ^ sub`.
- SPECIAL: classify NaN, Inf, zero and subnormal. Special results are latched and carried through the remaining states unchanged, so latency is identical.
  - Any NaN input → canonical NaN (sign 1, exponent all ones, fraction MSB 1, rest 0), invalid=1.
  - Inf − Inf (effective) → canonical NaN, invalid=1.
  - Single Inf → that Inf with its effective sign.
  - Both zero → zero with sign = `a_s & b_s_eff`.
  - One zero → the other operand exactly.
- ALIGN: barrel-shift the smaller-exponent mantissa right by the exponent difference. Shifted-out bits OR into sticky. Difference > MAN_W+3 gives mantissa 0, sticky = (operand≠0).
- ADD: equal effective signs add; otherwise subtract smaller magnitude from larger. Result sign is that of the larger operand. Exact cancellation gives +0. Sum width MAN_W+5 includes carry.
- NORM: on carry, shift right by 1 and exp+1, with sticky kept. Otherwise a leading-zero count shifts left until the hidden bit is set, clamped so exp ≥ 1−bias (subnormal floor).
- ROUND: round to nearest, ties to even. Mantissa overflow increments exp. Inexact = G|R|S ≠ 0.
- PACK: exp > bias → ±Inf, overflow=1, inexact=1. Subnormal result → exponent field 0.
- DONE: `done_strobe_o`=1 for exactly one cycle, `busy_o` drops; `z_value_o`/`flags_o` update on the same edge.

## Timing
- Strobe sampled at edge T. `done_strobe_o` is high during cycle T+8, and the result is valid from T+8.
- A new strobe is accepted in IDLE at the earliest at edge T+9. Throughput is 1 op / 9 cycles.
- `busy_o` is high from T+1 through T+8 inclusive.
- A strobe coincident with reset deassertion is ignored.

## Configuration
- `FP_ADDSUB_DENORM_EN` defined: subnormal inputs use exponent 1−bias without a hidden bit, and subnormal results are produced per IEEE-754.
- Undefined: subnormal inputs are treated as signed zero (flush-to-zero). Results below the normal range flush to zero of the result sign with inexact=1. The LZC clamp logic is removed.

## Test plan
- Default params: 0x3F800000 + 0x40000000, sub_i=0 → 0x40400000, flags 000, done pulse at T+8.
- 0x3F800000 − 0x3F800000 (sub_i=1) → 0x00000000. Separately, 0x7F800000 + 0xFF800000 → 0xFFC00000, flags 100.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags 011. Separately, 0x3F800000 + 0x33800000 (tie) → 0x3F800000, flags 001.
- 0x00000001 + 0x00000001 → 0x00000002 with `FP_ADDSUB_DENORM_EN`; → 0x00000000 with inexact=0 without it (inputs are flushed first).
- EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 → 0x4000. Also 0x7BFF + 0x7BFF → 0x7C00 with overflow.
- Assert `reset_n_i` low at T+4: outputs zero immediately, no done pulse. A strobe after release completes normally. A second strobe at T+3 is ignored.

Source files
------------

// File: rtl/fp_addsub_if.sv
// Strobe-handshake bundle for fp_addsub: operands, op select, result, flags and status.
interface fp_addsub_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic [W-1:0] a_value_i;
    logic [W-1:0] b_value_i;
    logic         sub_i;
    logic         exec_strobe_i;
    logic [W-1:0] z_value_o;
    logic         done_strobe_o;
    logic         busy_o;
    logic [2:0]   flags_o;

    modport master (
        output a_value_i, b_value_i, sub_i, exec_strobe_i,
        input  z_value_o, done_strobe_o, busy_o, flags_o
    );

    modport slave (
        input  a_value_i, b_value_i, sub_i, exec_strobe_i,
        output z_value_o, done_strobe_o, busy_o, flags_o
    );
endinterface

// File: rtl/fp_addsub.sv
// Parametrised IEEE-754 add/subtract, fixed 9-cycle strobe handshake, flags {invalid, overflow, inexact}.
// Define FP_ADDSUB_DENORM_EN for subnormal support; otherwise inputs/results flush to zero.
module fp_addsub #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic        clk,
    input logic        reset_n_i,
    fp_addsub_if.slave bus
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned MW   = MAN_W + 4;
    localparam int unsigned SW   = MAN_W + 5;
    localparam int unsigned LZW  = $clog2(MW + 1);
    localparam int unsigned XW   = EW + LZW + 1;
    localparam int          BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int          EMIN = 1 - BIAS;

    typedef enum logic [3:0] {
        StIdle, StCapture, StSpecial, StAlign, StAdd, StNorm, StRound, StPack, StDone
    } state_e;

    state_e state_q, state_d;
    logic   armed_q, accept, done_d, busy_d;

    // Operand capture / unpack
    logic [W-1:0]           a_q, b_q;
    logic                   sub_q;
    logic                   a_s_q, b_s_q;
    logic signed [EW-1:0]   a_e_q, b_e_q;
    logic [MW-1:0]          a_m_q, b_m_q;
    logic signed [EW-1:0]   a_e_d, b_e_d;
    logic [MW-1:0]          a_m_d, b_m_d;
    // Special-case result
    logic                   spec_d, spec_q;
    logic [W-1:0]           spec_z_d, spec_z_q;
    logic [2:0]             spec_f_d, spec_f_q;
    // Align / add / norm / round / pack
    logic [MW-1:0]          big_m_d, big_m_q, sml_m_d, sml_m_q;
    logic signed [EW-1:0]   big_e_d, big_e_q;
    logic                   big_s_d, big_s_q, sml_s_d, sml_s_q;
    logic [SW-1:0]          sum_d, sum_q;
    logic                   sgn_d, sgn_q;
    logic [MW-1:0]          nm_d, nm_q;
    logic signed [XW-1:0]   ne_d, ne_q;
    logic                   uf_d, uf_q;
    logic [MAN_W:0]         rm_d, rm_q;
    logic signed [XW-1:0]   re_d, re_q;
    logic                   inex_d, inex_q;
    logic [W-1:0]           pz_d, pz_q;
    logic [2:0]             pf_d, pf_q;

    function automatic void unpack(input logic [W-1:0] v, output logic signed [EW-1:0] e,
                                   output logic [MW-1:0] m);
        if (v[W-2 -: EXP_W] == '0) begin
            e = EW'(EMIN);
`ifdef FP_ADDSUB_DENORM_EN
            m = {1'b0, v[MAN_W-1:0], 3'b000};
`else
            m = '0;
`endif
        end else begin
            e = $signed({2'b00, v[W-2 -: EXP_W]}) - $signed(EW'(BIAS));
            m = {1'b1, v[MAN_W-1:0], 3'b000};
        end
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= StIdle;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StCapture;
            StCapture: state_d = StSpecial;
            StSpecial: state_d = StAlign;
            StAlign:   state_d = StAdd;
            StAdd:     state_d = StNorm;
            StNorm:    state_d = StRound;
            StRound:   state_d = StPack;
            StPack:    state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // armed_q masks a strobe on the first edge after reset release
    always_comb begin
        accept = (state_q == StIdle) && bus.exec_strobe_i && armed_q;
        done_d = (state_q == StDone);
        busy_d = (state_d != StIdle);
    end

    // ---------------- Datapath ----------------
    always_comb begin
        unpack(a_q, a_e_d, a_m_d);
        unpack(b_q, b_e_d, b_m_d);
    end

    always_comb begin
        logic [EXP_W-1:0] a_ef, b_ef;
        logic [MAN_W-1:0] a_ff, b_ff;
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, b_se;
        a_ef   = a_q[W-2 -: EXP_W];
        b_ef   = b_q[W-2 -: EXP_W];
        a_ff   = a_q[MAN_W-1:0];
        b_ff   = b_q[MAN_W-1:0];
        b_se   = b_q[W-1] ^ sub_q;
        a_nan  = (a_ef == '1) && (a_ff != '0);
        b_nan  = (b_ef == '1) && (b_ff != '0);
        a_inf  = (a_ef == '1) && (a_ff == '0);
        b_inf  = (b_ef == '1) && (b_ff == '0);
`ifdef FP_ADDSUB_DENORM_EN
        a_zero = (a_ef == '0) && (a_ff == '0);
        b_zero = (b_ef == '0) && (b_ff == '0);
`else
        a_zero = (a_ef == '0);
        b_zero = (b_ef == '0);
`endif
        spec_d   = 1'b1;
        spec_f_d = 3'b000;
        spec_z_d = a_q;
        if (a_nan || b_nan || (a_inf && b_inf && (a_q[W-1] != b_se))) begin
            spec_z_d = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            spec_f_d = 3'b100;
        end else if (a_inf) begin
            spec_z_d = a_q;
        end else if (b_inf) begin
            spec_z_d = {b_se, b_q[W-2:0]};
        end else if (a_zero && b_zero) begin
            spec_z_d = {a_q[W-1] & b_se, {(W-1){1'b0}}};
        end else if (a_zero) begin
            spec_z_d = {b_se, b_q[W-2:0]};
        end else if (b_zero) begin
            spec_z_d = a_q;
        end else begin
            spec_d = 1'b0;
        end
    end

    always_comb begin
        logic                 a_big, st;
        logic [MW-1:0]        sm;
        logic signed [EW-1:0] se;
        logic [EW-1:0]        diff;
        a_big   = (a_e_q > b_e_q) || ((a_e_q == b_e_q) && (a_m_q >= b_m_q));
        big_m_d = a_big ? a_m_q : b_m_q;
        big_e_d = a_big ? a_e_q : b_e_q;
        big_s_d = a_big ? a_s_q : b_s_q;
        sm      = a_big ? b_m_q : a_m_q;
        se      = a_big ? b_e_q : a_e_q;
        sml_s_d = a_big ? b_s_q : a_s_q;
        diff    = big_e_d - se;
        if (32'(diff) > 32'(MAN_W + 3)) begin
            sml_m_d = '0;
            st      = (sm != '0);
        end else begin
            sml_m_d = sm >> diff;
            st      = |(sm & ~({MW{1'b1}} << diff));
        end
        sml_m_d = sml_m_d | {{(MW-1){1'b0}}, st};
    end

    always_comb begin
        if (big_s_q == sml_s_q) sum_d = {1'b0, big_m_q} + {1'b0, sml_m_q};
        else                    sum_d = {1'b0, big_m_q} - {1'b0, sml_m_q};
        sgn_d = (sum_d == '0) ? 1'b0 : big_s_q;
    end

    always_comb begin
        logic [LZW-1:0]       lz;
        logic signed [XW-1:0] e_x, lz_x;
        e_x = XW'(big_e_q);
        lz  = LZW'(MW);
        for (int i = 0; i < int'(MW); i++) begin
            if (sum_q[i]) lz = LZW'(int'(MW) - 1 - i);
        end
        lz_x = $signed({{(XW-LZW){1'b0}}, lz});
        uf_d = 1'b0;
        if (sum_q[SW-1]) begin
            nm_d = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
            ne_d = e_x + XW'(1);
        end else begin
`ifdef FP_ADDSUB_DENORM_EN
            // Stop at the subnormal floor so tiny results keep their bits
            if (lz_x > e_x - XW'(EMIN)) lz_x = e_x - XW'(EMIN);
`endif
            nm_d = sum_q[MW-1:0] << lz_x;
            ne_d = e_x - lz_x;
`ifndef FP_ADDSUB_DENORM_EN
            uf_d = (sum_q != '0) && (ne_d < XW'(EMIN));
`endif
        end
    end

    always_comb begin
        logic           g, r, s, rup;
        logic [MAN_W+1:0] rm;
        g      = nm_q[2];
        r      = nm_q[1];
        s      = nm_q[0];
        rup    = g & (r | s | nm_q[3]);
        inex_d = g | r | s;
        rm     = {1'b0, nm_q[MW-1:3]} + (MAN_W+2)'(rup);
        if (rm[MAN_W+1]) begin
            rm_d = rm[MAN_W+1:1];
            re_d = ne_q + XW'(1);
        end else begin
            rm_d = rm[MAN_W:0];
            re_d = ne_q;
        end
    end

    always_comb begin
        logic signed [XW-1:0] eb;
        eb = re_q + XW'(BIAS);
        pz_d = {sgn_q, (rm_q[MAN_W] ? eb[EXP_W-1:0] : {EXP_W{1'b0}}), rm_q[MAN_W-1:0]};
        pf_d = {2'b00, inex_q};
        if (spec_q) begin
            pz_d = spec_z_q;
            pf_d = spec_f_q;
        end else if (uf_q) begin
            pz_d = {sgn_q, {(W-1){1'b0}}};
            pf_d = 3'b001;
        end else if (re_q > XW'(BIAS)) begin
            pz_d = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pf_d = 3'b011;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            armed_q <= 1'b0;
            a_q <= '0; b_q <= '0; sub_q <= 1'b0;
            a_s_q <= 1'b0; b_s_q <= 1'b0; a_e_q <= '0; b_e_q <= '0; a_m_q <= '0; b_m_q <= '0;
            spec_q <= 1'b0; spec_z_q <= '0; spec_f_q <= '0;
            big_m_q <= '0; sml_m_q <= '0; big_e_q <= '0; big_s_q <= 1'b0; sml_s_q <= 1'b0;
            sum_q <= '0; sgn_q <= 1'b0; nm_q <= '0; ne_q <= '0; uf_q <= 1'b0;
            rm_q <= '0; re_q <= '0; inex_q <= 1'b0; pz_q <= '0; pf_q <= '0;
            bus.z_value_o     <= '0;
            bus.flags_o       <= '0;
            bus.done_strobe_o <= 1'b0;
            bus.busy_o        <= 1'b0;
        end else begin
            armed_q           <= 1'b1;
            bus.done_strobe_o <= done_d;
            bus.busy_o        <= busy_d;
            if (accept) begin
                a_q   <= bus.a_value_i;
                b_q   <= bus.b_value_i;
                sub_q <= bus.sub_i;
            end
            if (state_q == StCapture) begin
                a_s_q <= a_q[W-1];
                b_s_q <= b_q[W-1] ^ sub_q;
                a_e_q <= a_e_d; b_e_q <= b_e_d;
                a_m_q <= a_m_d; b_m_q <= b_m_d;
            end
            if (state_q == StSpecial) begin
                spec_q <= spec_d; spec_z_q <= spec_z_d; spec_f_q <= spec_f_d;
            end
            if (state_q == StAlign) begin
                big_m_q <= big_m_d; sml_m_q <= sml_m_d; big_e_q <= big_e_d;
                big_s_q <= big_s_d; sml_s_q <= sml_s_d;
            end
            if (state_q == StAdd) begin
                sum_q <= sum_d; sgn_q <= sgn_d;
            end
            if (state_q == StNorm) begin
                nm_q <= nm_d; ne_q <= ne_d; uf_q <= uf_d;
            end
            if (state_q == StRound) begin
                rm_q <= rm_d; re_q <= re_d; inex_q <= inex_d;
            end
            if (state_q == StPack) begin
                pz_q <= pz_d; pf_q <= pf_d;
            end
            if (done_d) begin
                bus.z_value_o <= pz_q;
                bus.flags_o   <= pf_q;
            end
        end
    end
endmodule
